// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: loader-written word RAM with a LOAD/RUN FSM and a registered fetch port.
// Optional macro IFM_WR_BYPASS_EN forwards a same-edge loader write to the fetch result.
module instr_fetch_mem #(
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 64,
    parameter int                PC_SHIFT = 2,
    parameter logic [DATA_W-1:0] NOP_WORD = 16'h0800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       pc,
    input  logic              fetch_req,
    input  logic              MemConflict,
    input  logic              stall_in,
    input  logic              ld_we,
    input  logic [15:0]       ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    output logic [DATA_W-1:0] Instruction,
    output logic              inst_valid,
    output logic [15:0]       inst_pc,
    output logic              ready,
    output logic [7:0]        conflict_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [15:0]       pc_shifted_s;
    logic [IDX_W-1:0]  fetch_idx_s;
    logic [IDX_W-1:0]  ld_idx_s;
    logic [DATA_W-1:0] rd_word_s;

    logic [DATA_W-1:0] instr_nxt_s;
    logic              valid_nxt_s;
    logic [15:0]       inst_pc_nxt_s;
    logic [7:0]        cnt_nxt_s;

    assign pc_shifted_s = pc >> PC_SHIFT;
    assign fetch_idx_s  = pc_shifted_s[IDX_W-1:0];
    assign ld_idx_s     = ld_addr[IDX_W-1:0];
    assign ready        = (state_r == RUN);

    // Select the word a fetch returns this edge (optionally forwarding a colliding write)
    always_comb begin
        rd_word_s = mem_r[fetch_idx_s];
`ifdef IFM_WR_BYPASS_EN
        if (ld_we && (ld_idx_s == fetch_idx_s)) begin
            rd_word_s = ld_data;
        end else begin
            rd_word_s = mem_r[fetch_idx_s];
        end
`endif
    end

    // Memory write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem_r[ld_idx_s] <= ld_data;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and next output values; stall beats conflict, conflict beats fetch
    always_comb begin
        state_nxt_s   = state_r;
        instr_nxt_s   = Instruction;
        valid_nxt_s   = inst_valid;
        inst_pc_nxt_s = inst_pc;
        cnt_nxt_s     = conflict_cnt;
        case (state_r)
            LOAD: begin
                instr_nxt_s = NOP_WORD;
                valid_nxt_s = 1'b0;
                if (ld_done) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            RUN: begin
                state_nxt_s = RUN;
                if (stall_in) begin
                    instr_nxt_s = Instruction;
                end else if (fetch_req && MemConflict) begin
                    instr_nxt_s = NOP_WORD;
                    valid_nxt_s = 1'b0;
                    if (conflict_cnt != 8'hFF) begin
                        cnt_nxt_s = conflict_cnt + 8'd1;
                    end else begin
                        cnt_nxt_s = conflict_cnt;
                    end
                end else if (fetch_req) begin
                    instr_nxt_s   = rd_word_s;
                    valid_nxt_s   = 1'b1;
                    inst_pc_nxt_s = pc;
                end else begin
                    instr_nxt_s = NOP_WORD;
                    valid_nxt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = LOAD;
                instr_nxt_s = NOP_WORD;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered fetch outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Instruction  <= NOP_WORD;
            inst_valid   <= 1'b0;
            inst_pc      <= 16'h0000;
            conflict_cnt <= 8'h00;
        end else begin
            Instruction  <= instr_nxt_s;
            inst_valid   <= valid_nxt_s;
            inst_pc      <= inst_pc_nxt_s;
            conflict_cnt <= cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed self-checking bench for instr_fetch_mem (DEPTH=64, PC_SHIFT=2, NOP_WORD=0x0800).
module tb_instr_fetch_mem;

    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic        fetch_req;
    logic        MemConflict;
    logic        stall_in;
    logic        ld_we;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic        ld_done;
    logic [15:0] Instruction;
    logic        inst_valid;
    logic [15:0] inst_pc;
    logic        ready;
    logic [7:0]  conflict_cnt;

    int n_cmp;
    int n_err;

    instr_fetch_mem dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .fetch_req   (fetch_req),
        .MemConflict (MemConflict),
        .stall_in    (stall_in),
        .ld_we       (ld_we),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_done     (ld_done),
        .Instruction (Instruction),
        .inst_valid  (inst_valid),
        .inst_pc     (inst_pc),
        .ready       (ready),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_req   = 1'b0;
        MemConflict = 1'b0;
        stall_in    = 1'b0;
        ld_we       = 1'b0;
        ld_done     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pc = 16'h0000; ld_addr = 16'h0000; ld_data = 16'h0000;
        idle_inputs();
        #12;
        n_cmp++;
        if (Instruction !== 16'h0800 || inst_valid !== 1'b0 || inst_pc !== 16'h0000 ||
            conflict_cnt !== 8'h00 || ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset: instr=%h valid=%b pc=%h cnt=%0d ready=%b, want 0800/0/0000/0/0",
                     Instruction, inst_valid, inst_pc, conflict_cnt, ready);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic load_word(input logic [15:0] a, input logic [15:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        fetch_req = 1'b1; pc = 16'h0000;
        tick();
        ld_we = 1'b0; fetch_req = 1'b0;
        n_cmp++;
        if (Instruction !== 16'h0800 || inst_valid !== 1'b0 || ready !== 1'b0) begin
            n_err++;
            $display("FAIL load_ignore: instr=%h valid=%b ready=%b, want 0800/0/0",
                     Instruction, inst_valid, ready);
        end
    endtask

    task automatic fetch_chk(input string nm, input logic [15:0] a, input logic [15:0] exp);
        fetch_req = 1'b1; pc = a;
        tick();
        fetch_req = 1'b0;
        n_cmp++;
        if (Instruction !== exp || inst_valid !== 1'b1 || inst_pc !== a) begin
            n_err++;
            $display("FAIL %s: instr=%h valid=%b pc=%h, want %h/1/%h",
                     nm, Instruction, inst_valid, inst_pc, exp, a);
        end
    endtask

    task automatic test_load_and_fetch();
        load_word(16'h0000, 16'h4A05);
        load_word(16'h0001, 16'hD844);
        load_word(16'h0003, 16'h1111);
        load_word(16'h0005, 16'h1234);
        load_word(16'h0047, 16'h7777);
        ld_done = 1'b1; fetch_req = 1'b1; pc = 16'h0000;
        tick();
        ld_done = 1'b0; fetch_req = 1'b0;
        n_cmp++;
        if (ready !== 1'b1 || inst_valid !== 1'b0 || Instruction !== 16'h0800) begin
            n_err++;
            $display("FAIL ld_done_edge: ready=%b valid=%b instr=%h, want 1/0/0800",
                     ready, inst_valid, Instruction);
        end
        fetch_chk("fetch_pc0", 16'h0000, 16'h4A05);
    endtask

    task automatic test_wrap();
        fetch_chk("pc_wrap", 16'h0104, 16'hD844);
        fetch_chk("ld_addr_wrap", 16'h001C, 16'h7777);
    endtask

    task automatic test_idle();
        fetch_req = 1'b0; MemConflict = 1'b1;
        tick();
        MemConflict = 1'b0;
        n_cmp++;
        if (Instruction !== 16'h0800 || inst_valid !== 1'b0 || conflict_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL idle: instr=%h valid=%b cnt=%0d, want 0800/0/0",
                     Instruction, inst_valid, conflict_cnt);
        end
    endtask

    task automatic test_conflict();
        logic [7:0] exp_cnt;
        int bad;
        bad = 0;
        fetch_req = 1'b1; MemConflict = 1'b1; pc = 16'h0000;
        for (int i = 1; i <= 300; i++) begin
            tick();
            exp_cnt = (i < 255) ? i[7:0] : 8'd255;
            n_cmp++;
            if (Instruction !== 16'h0800 || inst_valid !== 1'b0 || conflict_cnt !== exp_cnt) begin
                n_err++;
                if (bad < 5)
                    $display("FAIL conflict[%0d]: instr=%h valid=%b cnt=%0d, want 0800/0/%0d",
                             i, Instruction, inst_valid, conflict_cnt, exp_cnt);
                bad++;
            end
        end
        fetch_req = 1'b0; MemConflict = 1'b0;
    endtask

    task automatic test_bypass();
        logic [15:0] exp;
`ifdef IFM_WR_BYPASS_EN
        exp = 16'h2222;
`else
        exp = 16'h1111;
`endif
        ld_we = 1'b1; ld_addr = 16'h0003; ld_data = 16'h2222;
        fetch_chk("wr_collide", 16'h000C, exp);
        ld_we = 1'b0;
        fetch_chk("after_write", 16'h000C, 16'h2222);
    endtask

    task automatic test_reset_midrun();
        fetch_req = 1'b1; pc = 16'h0014;
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (Instruction !== 16'h0800 || inst_valid !== 1'b0 || inst_pc !== 16'h0000 ||
            conflict_cnt !== 8'h00 || ready !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_reset: instr=%h valid=%b pc=%h cnt=%0d ready=%b, want 0800/0/0000/0/0",
                     Instruction, inst_valid, inst_pc, conflict_cnt, ready);
        end
        #2;
        rst = 1'b1;
        tick();
        n_cmp++;
        if (Instruction !== 16'h0800 || inst_valid !== 1'b0 || ready !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_fetch: instr=%h valid=%b ready=%b, want 0800/0/0",
                     Instruction, inst_valid, ready);
        end
        fetch_req = 1'b0; ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL reload_ready: ready=%b, want 1", ready);
        end
        fetch_chk("retained_0", 16'h0000, 16'h4A05);
        fetch_chk("retained_3", 16'h000C, 16'h2222);
    endtask

    task automatic test_stall();
        fetch_chk("pre_stall", 16'h0014, 16'h1234);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_req = 1'b1;
            MemConflict = i[0];
            pc = 16'h0000;
            tick();
            n_cmp++;
            if (Instruction !== 16'h1234 || inst_valid !== 1'b1 || inst_pc !== 16'h0014 ||
                conflict_cnt !== 8'd0) begin
                n_err++;
                $display("FAIL stall[%0d]: instr=%h valid=%b pc=%h cnt=%0d, want 1234/1/0014/0",
                         i, Instruction, inst_valid, inst_pc, conflict_cnt);
            end
        end
        stall_in = 1'b0;
        fetch_req = 1'b1; MemConflict = 1'b1;
        tick();
        idle_inputs();
        n_cmp++;
        if (conflict_cnt !== 8'd1 || inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_stall_conflict: cnt=%0d valid=%b, want 1/0", conflict_cnt, inst_valid);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_load_and_fetch();
        test_wrap();
        test_idle();
        test_conflict();
        test_bypass();
        test_reset_midrun();
        test_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, number of words; power of two, 8 to 1024.
REQ-003 SHALL have parameter PC_SHIFT, default 2, right shift applied to pc to form the word index.
REQ-004 SHALL have parameter NOP_WORD, default 16'h0800, word driven on bubbles and after reset.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port pc, input, 16, fetch byte address.
REQ-008 SHALL have port fetch_req, input, 1, fetch request for pc this cycle.
REQ-009 SHALL have port MemConflict, input, 1, data-side access owns memory this cycle; fetch is suppressed.
REQ-010 SHALL have port stall_in, input, 1, decode stage not accepting; hold outputs.
REQ-011 SHALL have port ld_we, input, 1, loader/store write enable.
REQ-012 SHALL have port ld_addr, input, 16, write word index; taken modulo DEPTH.
REQ-013 SHALL have port ld_data, input, DATA_W, write data.
REQ-014 SHALL have port ld_done, input, 1, program load complete.
REQ-015 SHALL have port Instruction, output, DATA_W, registered instruction.
REQ-016 SHALL have port inst_valid, output, 1, Instruction is a real fetch result.
REQ-017 SHALL have port inst_pc, output, 16, pc belonging to Instruction.
REQ-018 SHALL have port ready, output, 1, high in state RUN.
REQ-019 SHALL have port conflict_cnt, output, 8, saturating count of conflict-suppressed fetches.

Function
REQ-020 SHALL implement a two-state FSM: LOAD (entered on reset) and RUN; LOAD->RUN on the edge where ld_done=1; RUN has no exit except reset.
REQ-021 SHALL compute the word index as (pc >> PC_SHIFT) mod DEPTH; addresses beyond DEPTH wrap with no error.
REQ-022 SHALL write ld_data to mem[ld_addr mod DEPTH] on any edge with ld_we=1, in both states.
REQ-023 SHALL, in LOAD, ignore fetch_req and keep Instruction=NOP_WORD, inst_valid=0.
REQ-024 SHALL, in RUN with stall_in=1, hold Instruction, inst_valid, inst_pc and conflict_cnt unchanged regardless of other inputs.
REQ-025 SHALL, in RUN with stall_in=0, fetch_req=1, MemConflict=0, present mem[index], inst_valid=1, inst_pc=pc on the next edge (1-cycle latency).
REQ-026 SHALL, in RUN with stall_in=0, fetch_req=1, MemConflict=1, present NOP_WORD, inst_valid=0, and increment conflict_cnt, saturating at 255.
REQ-027 SHALL, in RUN with stall_in=0, fetch_req=0, present NOP_WORD, inst_valid=0; conflict_cnt unchanged.
REQ-028 SHALL give stall_in priority over MemConflict, and MemConflict priority over fetch_req.

Reset
REQ-029 SHALL on rst=0, asynchronously: state=LOAD, Instruction=NOP_WORD, inst_valid=0, inst_pc=0, conflict_cnt=0, ready=0.
REQ-030 SHALL retain memory contents across reset; reset mid-fetch discards the in-flight result only.

Configuration
REQ-031 SHALL, with IFM_WR_BYPASS_EN defined, return ld_data when ld_we and an accepted fetch hit the same index on one edge.
REQ-032 SHALL, without IFM_WR_BYPASS_EN, return the pre-write word in that case; the write still completes.

Verification
REQ-033 SHALL test: reset, write 0x4A05 at idx0, ld_done, fetch pc=0 -> next cycle Instruction=0x4A05, inst_valid=1, inst_pc=0.
REQ-034 SHALL test: DEPTH=64, mem[1]=0xD844, fetch pc=0x0104 -> Instruction=0xD844 (index 65 wraps to 1).
REQ-035 SHALL test: 300 fetches with MemConflict=1 -> each Instruction=0x0800, inst_valid=0, conflict_cnt stops at 255.
REQ-036 SHALL test: valid output 0x1234, then stall_in=1 for 3 cycles with new fetches -> outputs stay 0x1234, valid=1.
REQ-037 SHALL test: mem[3]=0x1111, ld_we writes 0x2222 to idx3 while fetching pc=0x000C -> 0x2222 with macro, 0x1111 without; next fetch 0x2222.
REQ-038 SHALL test: rst pulsed low mid-RUN -> outputs reset immediately, ready=0, fetches ignored until ld_done, prior contents still readable.
